// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control-transfer encodings and the redirect sequencer state type.
// Imported by the branch condition evaluator and the redirect controller.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;

  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  localparam logic [4:0] RT_BLTZ    = 5'h00;
  localparam logic [4:0] RT_BGEZ    = 5'h01;
  localparam logic [4:0] RT_BLTZAL  = 5'h10;
  localparam logic [4:0] RT_BGEZAL  = 5'h11;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_DS,
    ST_REDIRECT
  } redir_state_e;

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational decode of a control-transfer instruction: is it one, is it taken,
// and does it write a link register (o_link_sel=1 selects the rd field, else LINK_REG).
module branch_cond_eval
  import mips_ctrl_pkg::*;
(
  input  logic [31:0] i_inst,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  output logic        o_is_ctrl,
  output logic        o_taken,
  output logic        o_is_link,
  output logic        o_link_sel
);

  logic [5:0] w_op;
  logic [5:0] w_fn;
  logic [4:0] w_rt_field;
  logic       w_rs_neg;
  logic       w_rs_zero;
  logic       w_eq;
  logic       w_unused;

  assign w_op       = i_inst[31:26];
  assign w_fn       = i_inst[5:0];
  assign w_rt_field = i_inst[20:16];
  assign w_rs_neg   = i_rs[31];
  assign w_rs_zero  = (i_rs == 32'd0);
  assign w_eq       = (i_rs == i_rt);
  assign w_unused   = ^{i_inst[25:21], i_inst[15:6]};

  // Signed comparisons against zero reduce to the sign bit plus a zero test.
  always_comb begin
    o_is_ctrl  = 1'b0;
    o_taken    = 1'b0;
    o_is_link  = 1'b0;
    o_link_sel = 1'b0;
    case (w_op)
      OP_SPECIAL: begin
        if (w_fn == FN_JR) begin
          o_is_ctrl = 1'b1;
          o_taken   = 1'b1;
        end else if (w_fn == FN_JALR) begin
          o_is_ctrl  = 1'b1;
          o_taken    = 1'b1;
          o_is_link  = 1'b1;
          o_link_sel = 1'b1;
        end
      end
      OP_REGIMM: begin
        case (w_rt_field)
          RT_BLTZ: begin
            o_is_ctrl = 1'b1;
            o_taken   = w_rs_neg;
          end
          RT_BGEZ: begin
            o_is_ctrl = 1'b1;
            o_taken   = ~w_rs_neg;
          end
          RT_BLTZAL: begin
            o_is_ctrl = 1'b1;
            o_taken   = w_rs_neg;
            o_is_link = 1'b1;
          end
          RT_BGEZAL: begin
            o_is_ctrl = 1'b1;
            o_taken   = ~w_rs_neg;
            o_is_link = 1'b1;
          end
          default: ;
        endcase
      end
      OP_J: begin
        o_is_ctrl = 1'b1;
        o_taken   = 1'b1;
      end
      OP_JAL: begin
        o_is_ctrl = 1'b1;
        o_taken   = 1'b1;
        o_is_link = 1'b1;
      end
      OP_BEQ: begin
        o_is_ctrl = 1'b1;
        o_taken   = w_eq;
      end
      OP_BNE: begin
        o_is_ctrl = 1'b1;
        o_taken   = ~w_eq;
      end
      OP_BLEZ: begin
        o_is_ctrl = 1'b1;
        o_taken   = w_rs_neg | w_rs_zero;
      end
      OP_BGTZ: begin
        o_is_ctrl = 1'b1;
        o_taken   = ~w_rs_neg & ~w_rs_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/branch_redirect_ctrl.sv
// Resolves control transfers in ID, waits for the delay slot to be fetched, then
// hands IF a redirect; also issues link writes and counts taken/not-taken transfers.
module branch_redirect_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int         CNT_W    = 32,
  parameter logic [4:0] LINK_REG = 5'd31
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic             id_stall,
  input  logic [31:0]      id_inst,
  input  logic [31:0]      id_pc,
  input  logic [31:0]      rs_data,
  input  logic [31:0]      rt_data,
  input  logic [31:0]      target_addr,
  input  logic             flush,
  input  logic             ds_fetched,
  input  logic             redirect_ready,
  output logic             redirect_valid,
  output logic [31:0]      redirect_pc,
  output logic             in_delay_slot,
  output logic             link_we,
  output logic [4:0]       link_rd,
  output logic [31:0]      link_data,
  output logic             ds_branch_err,
  output logic [CNT_W-1:0] taken_cnt,
  output logic [CNT_W-1:0] nt_cnt
);

  logic             w_is_ctrl;
  logic             w_taken;
  logic             w_is_link;
  logic             w_link_sel;
  logic             w_accept;
  logic             w_idle_accept;
  logic             w_ds_accept;
  redir_state_e     r_state;
  redir_state_e     w_state_nxt;
  logic [31:0]      r_target;
  logic             r_link_we;
  logic [4:0]       r_link_rd;
  logic [31:0]      r_link_data;
  logic             r_ds_err;
  logic [CNT_W-1:0] r_taken_cnt;
  logic [CNT_W-1:0] r_nt_cnt;

  branch_cond_eval u_eval (
    .i_inst     (id_inst),
    .i_rs       (rs_data),
    .i_rt       (rt_data),
    .o_is_ctrl  (w_is_ctrl),
    .o_taken    (w_taken),
    .o_is_link  (w_is_link),
    .o_link_sel (w_link_sel)
  );

  assign w_accept      = id_valid & ~id_stall & ~flush & w_is_ctrl;
  assign w_idle_accept = w_accept & (r_state == ST_IDLE);
  // A transfer arriving while one is still in flight sits in a delay slot.
  assign w_ds_accept   = w_accept & (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (flush) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (w_idle_accept && w_taken) w_state_nxt = ST_WAIT_DS;
        ST_WAIT_DS:  if (ds_fetched)               w_state_nxt = ST_REDIRECT;
        ST_REDIRECT: if (redirect_ready)           w_state_nxt = ST_IDLE;
        default:                                   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_target    <= '0;
      r_link_we   <= 1'b0;
      r_link_rd   <= '0;
      r_link_data <= '0;
      r_ds_err    <= 1'b0;
      r_taken_cnt <= '0;
      r_nt_cnt    <= '0;
    end else begin
      r_link_we <= w_idle_accept & w_is_link;
      r_ds_err  <= w_ds_accept;
      if (flush)
        r_target <= '0;
      else if (w_idle_accept && w_taken)
        r_target <= target_addr;
      if (w_idle_accept && w_is_link) begin
        r_link_rd   <= w_link_sel ? id_inst[15:11] : LINK_REG;
        r_link_data <= id_pc + 32'd8;
      end
      if (w_idle_accept && w_taken && (r_taken_cnt != '1))
        r_taken_cnt <= r_taken_cnt + 1'b1;
      if (w_idle_accept && !w_taken && (r_nt_cnt != '1))
        r_nt_cnt <= r_nt_cnt + 1'b1;
    end
  end

  assign redirect_valid = (r_state == ST_REDIRECT);
  assign redirect_pc    = redirect_valid ? r_target : 32'd0;
  assign in_delay_slot  = (r_state == ST_WAIT_DS);
  assign link_we        = r_link_we;
  assign link_rd        = r_link_we ? r_link_rd : 5'd0;
  assign link_data      = r_link_we ? r_link_data : 32'd0;
  assign ds_branch_err  = r_ds_err;
  assign taken_cnt      = r_taken_cnt;
  assign nt_cnt         = r_nt_cnt;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios plus a random
// run, all compared against a transaction-level model of the redirect sequence.
module tb_branch_redirect_ctrl;

  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          id_valid = 1'b0, id_stall = 1'b0, flush = 1'b0;
  logic          ds_fetched = 1'b0, redirect_ready = 1'b0;
  logic [31:0]   id_inst = '0, id_pc = '0, rs_data = '0, rt_data = '0, target_addr = '0;
  logic          redirect_valid, in_delay_slot, link_we, ds_branch_err;
  logic [31:0]   redirect_pc, link_data;
  logic [4:0]    link_rd;
  logic [CW-1:0] taken_cnt, nt_cnt;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  branch_redirect_ctrl #(.CNT_W(CW), .LINK_REG(5'd31)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_stall(id_stall), .id_inst(id_inst),
    .id_pc(id_pc), .rs_data(rs_data), .rt_data(rt_data), .target_addr(target_addr),
    .flush(flush), .ds_fetched(ds_fetched), .redirect_ready(redirect_ready),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .in_delay_slot(in_delay_slot),
    .link_we(link_we), .link_rd(link_rd), .link_data(link_data),
    .ds_branch_err(ds_branch_err), .taken_cnt(taken_cnt), .nt_cnt(nt_cnt)
  );

  // Model: a transfer is "pending" from taken accept until IF takes the redirect.
  bit          mPend, mDsDone, mLinkWe, mErr;
  logic [31:0] mTgt, mLinkData;
  logic [4:0]  mLinkRd;
  int          mTaken, mNt;

  function automatic logic [31:0] encI(input logic [5:0] op, input logic [4:0] rsr,
                                       input logic [4:0] rtr, input logic [15:0] imm);
    return {op, rsr, rtr, imm};
  endfunction

  function automatic logic [31:0] encR(input logic [5:0] fn, input logic [4:0] rsr,
                                       input logic [4:0] rdr);
    return {6'd0, rsr, 5'd0, rdr, 5'd0, fn};
  endfunction

  function automatic void decode(input logic [31:0] inst, input logic [31:0] rs,
                                 input logic [31:0] rt, output bit ctrl, output bit taken,
                                 output bit link, output logic [4:0] rd);
    int op  = int'(inst[31:26]);
    int fn  = int'(inst[5:0]);
    int rtf = int'(inst[20:16]);
    int srs = $signed(rs);
    int srt = $signed(rt);
    ctrl = 0; taken = 0; link = 0; rd = 5'd31;
    case (op)
      0: if (fn == 8) begin ctrl = 1; taken = 1; end
         else if (fn == 9) begin ctrl = 1; taken = 1; link = 1; rd = inst[15:11]; end
      1: if (rtf == 0 || rtf == 16) begin ctrl = 1; taken = (srs < 0); link = (rtf == 16); end
         else if (rtf == 1 || rtf == 17) begin ctrl = 1; taken = (srs >= 0); link = (rtf == 17); end
      2: begin ctrl = 1; taken = 1; end
      3: begin ctrl = 1; taken = 1; link = 1; end
      4: begin ctrl = 1; taken = (srs == srt); end
      5: begin ctrl = 1; taken = (srs != srt); end
      6: begin ctrl = 1; taken = (srs <= 0); end
      7: begin ctrl = 1; taken = (srs > 0); end
      default: ;
    endcase
  endfunction

  function void modelStep();
    bit c, t, l, acc;
    logic [4:0] rd;
    decode(id_inst, rs_data, rt_data, c, t, l, rd);
    mLinkWe = 0;
    mErr    = 0;
    if (rst) begin
      mPend = 0; mDsDone = 0; mTgt = '0; mTaken = 0; mNt = 0;
      mLinkRd = '0; mLinkData = '0;
      return;
    end
    acc = id_valid && !id_stall && !flush && c;
    if (flush) begin
      mPend = 0; mDsDone = 0;
    end else if (!mPend) begin
      if (acc) begin
        if (l) begin mLinkWe = 1; mLinkRd = rd; mLinkData = id_pc + 32'd8; end
        if (t) begin
          mPend = 1; mDsDone = 0; mTgt = target_addr;
          if (mTaken < CMAX) mTaken++;
        end else if (mNt < CMAX) mNt++;
      end
    end else begin
      if (acc) mErr = 1;
      if (!mDsDone) begin
        if (ds_fetched) mDsDone = 1;
      end else if (redirect_ready) mPend = 0;
    end
  endfunction

  task automatic applyStimulus(input bit v, input bit st, input bit fl, input bit dsf,
                               input bit rdy, input logic [31:0] inst, input logic [31:0] pc,
                               input logic [31:0] rs, input logic [31:0] rt,
                               input logic [31:0] tgt);
    id_valid = v; id_stall = st; flush = fl; ds_fetched = dsf; redirect_ready = rdy;
    id_inst = inst; id_pc = pc; rs_data = rs; rt_data = rt; target_addr = tgt;
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic idleCycle(input bit dsf, input bit rdy);
    applyStimulus(0, 0, 0, dsf, rdy, 32'h0000_0021, 32'h0, 32'h0, 32'h0, 32'h0);
  endtask

  task automatic doReset();
    rst = 1'b1;
    applyStimulus(1, 0, 0, 1, 1, encI(6'h03, 5'd0, 5'd0, 16'h0), 32'h1000, 32'h1, 32'h1, 32'hABCD);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    doReset();
    checks++;
    if ({redirect_valid, redirect_pc, in_delay_slot, ds_branch_err} !== 35'd0) begin
      failures++;
      $display("[TB] FAIL reset_redirect got=%b/%h/%b/%b exp=0", redirect_valid, redirect_pc, in_delay_slot, ds_branch_err);
    end
    checks++;
    if ({link_we, link_rd, link_data, taken_cnt, nt_cnt} !== '0) begin
      failures++;
      $display("[TB] FAIL reset_link_cnt got=%b/%h/%h/%0d/%0d exp=0", link_we, link_rd, link_data, taken_cnt, nt_cnt);
    end
  endtask

  task automatic test_beq_taken();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, encI(6'h04, 5'd1, 5'd2, 16'h10), 32'h0040_0000, 32'd5, 32'd5, 32'h0040_0040);
    checks++;
    if (in_delay_slot !== 1'b1 || redirect_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL beq_wait_ds got=ds%b/v%b exp=ds1/v0", in_delay_slot, redirect_valid);
    end
    applyStimulus(1, 0, 0, 1, 0, 32'h0000_0021, 32'h0040_0004, 32'd0, 32'd0, 32'h0);
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0040 || in_delay_slot !== 1'b0) begin
      failures++; $display("[TB] FAIL beq_redirect got=v%b/pc%h/ds%b exp=v1/pc00400040/ds0", redirect_valid, redirect_pc, in_delay_slot);
    end
    idleCycle(0, 1);
    checks++;
    if (redirect_valid !== 1'b0 || taken_cnt !== 6'd1 || nt_cnt !== 6'd0) begin
      failures++; $display("[TB] FAIL beq_done got=v%b/t%0d/n%0d exp=v0/t1/n0", redirect_valid, taken_cnt, nt_cnt);
    end
  endtask

  task automatic test_bne_not_taken();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, encI(6'h05, 5'd3, 5'd4, 16'h8), 32'h0040_0010, 32'd7, 32'd7, 32'h0040_0200);
    idleCycle(1, 1);
    checks++;
    if (redirect_valid !== 1'b0 || in_delay_slot !== 1'b0 || nt_cnt !== 6'd1 || taken_cnt !== 6'd0) begin
      failures++; $display("[TB] FAIL bne_nt got=v%b/ds%b/n%0d/t%0d exp=v0/ds0/n1/t0", redirect_valid, in_delay_slot, nt_cnt, taken_cnt);
    end
  endtask

  task automatic test_jal_link();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, encI(6'h03, 5'd0, 5'd0, 16'h40), 32'h0040_0100, 32'd0, 32'd0, 32'h0050_0000);
    checks++;
    if (link_we !== 1'b1 || link_rd !== 5'd31 || link_data !== 32'h0040_0108) begin
      failures++; $display("[TB] FAIL jal_link got=we%b/rd%0d/d%h exp=we1/rd31/d00400108", link_we, link_rd, link_data);
    end
    applyStimulus(1, 0, 0, 1, 0, 32'h0000_0021, 32'h0040_0104, 32'd0, 32'd0, 32'h0);
    checks++;
    if (link_we !== 1'b0) begin
      failures++; $display("[TB] FAIL jal_link_pulse got=%b exp=0", link_we);
    end
    for (int i = 0; i < 2; i++) begin
      idleCycle(0, 0);
      checks++;
      if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0050_0000) begin
        failures++; $display("[TB] FAIL jal_hold got=v%b/pc%h exp=v1/pc00500000", redirect_valid, redirect_pc);
      end
    end
    idleCycle(0, 1);
    checks++;
    if (redirect_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL jal_complete got=%b exp=0", redirect_valid);
    end
    // JALR at the top of the address space: rd field destination, link wraps.
    applyStimulus(1, 0, 0, 0, 0, encR(6'h09, 5'd2, 5'd7), 32'hFFFF_FFFC, 32'h0000_3000, 32'd0, 32'h0000_3000);
    checks++;
    if (link_we !== 1'b1 || link_rd !== 5'd7 || link_data !== 32'h0000_0004) begin
      failures++; $display("[TB] FAIL jalr_wrap got=we%b/rd%0d/d%h exp=we1/rd7/d00000004", link_we, link_rd, link_data);
    end
  endtask

  task automatic test_signed_regimm();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, encI(6'h01, 5'd5, 5'h01, 16'h4), 32'h0040_0020, 32'h8000_0000, 32'd0, 32'h0040_0400);
    checks++;
    if (nt_cnt !== 6'd1 || taken_cnt !== 6'd0 || in_delay_slot !== 1'b0) begin
      failures++; $display("[TB] FAIL bgez_neg got=n%0d/t%0d/ds%b exp=n1/t0/ds0", nt_cnt, taken_cnt, in_delay_slot);
    end
    applyStimulus(1, 0, 0, 0, 0, encI(6'h01, 5'd5, 5'h00, 16'h4), 32'h0040_0024, 32'h8000_0000, 32'd0, 32'h0040_0500);
    checks++;
    if (taken_cnt !== 6'd1 || in_delay_slot !== 1'b1) begin
      failures++; $display("[TB] FAIL bltz_neg got=t%0d/ds%b exp=t1/ds1", taken_cnt, in_delay_slot);
    end
  endtask

  task automatic test_ds_branch_err();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, encI(6'h04, 5'd1, 5'd1, 16'h4), 32'h0040_0000, 32'd9, 32'd9, 32'h0040_0800);
    applyStimulus(1, 0, 0, 0, 0, encR(6'h08, 5'd4, 5'd0), 32'h0040_0004, 32'h1234_0000, 32'd0, 32'h1234_0000);
    checks++;
    if (ds_branch_err !== 1'b1 || taken_cnt !== 6'd1 || nt_cnt !== 6'd0 || link_we !== 1'b0) begin
      failures++; $display("[TB] FAIL ds_err_pulse got=e%b/t%0d/n%0d/l%b exp=e1/t1/n0/l0", ds_branch_err, taken_cnt, nt_cnt, link_we);
    end
    idleCycle(1, 0);
    checks++;
    if (ds_branch_err !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== 32'h0040_0800) begin
      failures++; $display("[TB] FAIL ds_err_target got=e%b/v%b/pc%h exp=e0/v1/pc00400800", ds_branch_err, redirect_valid, redirect_pc);
    end
    applyStimulus(1, 0, 0, 0, 0, encR(6'h09, 5'd4, 5'd9), 32'h0040_0800, 32'h5, 32'd0, 32'h5);
    checks++;
    if (ds_branch_err !== 1'b1 || link_we !== 1'b0 || redirect_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL ds_err_redirect got=e%b/l%b/v%b exp=e1/l0/v1", ds_branch_err, link_we, redirect_valid);
    end
    idleCycle(0, 1);
  endtask

  task automatic test_flush();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, encI(6'h02, 5'd0, 5'd0, 16'h80), 32'h0040_0000, 32'd0, 32'd0, 32'h0040_0200);
    idleCycle(1, 0);
    applyStimulus(0, 0, 1, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
    checks++;
    if (redirect_valid !== 1'b0 || in_delay_slot !== 1'b0 || taken_cnt !== 6'd1) begin
      failures++; $display("[TB] FAIL flush_redirect got=v%b/ds%b/t%0d exp=v0/ds0/t1", redirect_valid, in_delay_slot, taken_cnt);
    end
    applyStimulus(1, 0, 1, 1, 1, encI(6'h04, 5'd1, 5'd1, 16'h4), 32'h0040_0300, 32'd3, 32'd3, 32'h0040_0900);
    checks++;
    if (in_delay_slot !== 1'b0 || redirect_valid !== 1'b0 || taken_cnt !== 6'd1 || nt_cnt !== 6'd0) begin
      failures++; $display("[TB] FAIL flush_beats_accept got=ds%b/v%b/t%0d/n%0d exp=ds0/v0/t1/n0", in_delay_slot, redirect_valid, taken_cnt, nt_cnt);
    end
  endtask

  task automatic test_reset_mid();
    doReset();
    applyStimulus(1, 0, 0, 0, 0, encI(6'h03, 5'd0, 5'd0, 16'h40), 32'h0040_0100, 32'd0, 32'd0, 32'h0050_0000);
    rst = 1'b1;
    idleCycle(1, 0);
    rst = 1'b0;
    checks++;
    if ({redirect_valid, in_delay_slot, link_we, ds_branch_err, taken_cnt, nt_cnt, redirect_pc} !== '0) begin
      failures++; $display("[TB] FAIL reset_mid got=v%b/ds%b/l%b/e%b/t%0d/n%0d exp=all0", redirect_valid, in_delay_slot, link_we, ds_branch_err, taken_cnt, nt_cnt);
    end
  endtask

  task automatic test_saturation();
    doReset();
    for (int i = 0; i < CMAX + 5; i++)
      applyStimulus(1, 0, 0, 0, 0, encI(6'h05, 5'd1, 5'd2, 16'h4), 32'h100, 32'd1, 32'd1, 32'h200);
    checks++;
    if (nt_cnt !== 6'd63) begin
      failures++; $display("[TB] FAIL nt_saturate got=%0d exp=63", nt_cnt);
    end
    for (int i = 0; i < CMAX + 3; i++) begin
      applyStimulus(1, 0, 0, 0, 0, encI(6'h02, 5'd0, 5'd0, 16'h4), 32'h100, 32'd0, 32'd0, 32'h400);
      idleCycle(1, 0);
      idleCycle(0, 1);
    end
    checks++;
    if (taken_cnt !== 6'd63 || nt_cnt !== 6'd63) begin
      failures++; $display("[TB] FAIL taken_saturate got=t%0d/n%0d exp=t63/n63", taken_cnt, nt_cnt);
    end
  endtask

  task automatic test_random();
    logic [31:0] inst, rsv, rtv;
    logic [4:0]  r1, r2;
    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r1 = 5'($urandom); r2 = 5'($urandom);
      case ($urandom_range(0, 13))
        0:  inst = encI(6'h02, r1, r2, 16'($urandom));
        1:  inst = encI(6'h03, r1, r2, 16'($urandom));
        2:  inst = encI(6'h04, r1, r2, 16'($urandom));
        3:  inst = encI(6'h05, r1, r2, 16'($urandom));
        4:  inst = encI(6'h06, r1, 5'd0, 16'($urandom));
        5:  inst = encI(6'h07, r1, 5'd0, 16'($urandom));
        6:  inst = encI(6'h01, r1, 5'h00, 16'($urandom));
        7:  inst = encI(6'h01, r1, 5'h01, 16'($urandom));
        8:  inst = encI(6'h01, r1, 5'h10, 16'($urandom));
        9:  inst = encI(6'h01, r1, 5'h11, 16'($urandom));
        10: inst = encR(6'h08, r1, r2);
        11: inst = encR(6'h09, r1, r2);
        12: inst = encR(6'h21, r1, r2);
        default: inst = encI(6'h01, r1, 5'h02, 16'($urandom));
      endcase
      case ($urandom_range(0, 5))
        0: rsv = 32'h0;
        1: rsv = 32'h1;
        2: rsv = 32'hFFFF_FFFF;
        3: rsv = 32'h8000_0000;
        4: rsv = 32'h7FFF_FFFF;
        default: rsv = $urandom;
      endcase
      rtv = ($urandom_range(0, 1) == 0) ? rsv : $urandom;
      rst = ($urandom_range(0, 199) == 0);
      applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 6) == 0, $urandom_range(0, 24) == 0,
                    $urandom_range(0, 4) < 2, $urandom_range(0, 1) == 1, inst, $urandom, rsv, rtv, $urandom);
      rst = 1'b0;
      checks++;
      if (redirect_valid !== (mPend && mDsDone) || redirect_pc !== ((mPend && mDsDone) ? mTgt : 32'h0)) begin
        failures++; $display("[TB] FAIL rnd_redirect cyc=%0d got=v%b/pc%h exp=v%b/pc%h", cyc, redirect_valid, redirect_pc, mPend && mDsDone, (mPend && mDsDone) ? mTgt : 32'h0);
      end
      checks++;
      if (in_delay_slot !== (mPend && !mDsDone) || ds_branch_err !== mErr) begin
        failures++; $display("[TB] FAIL rnd_ds cyc=%0d got=ds%b/e%b exp=ds%b/e%b", cyc, in_delay_slot, ds_branch_err, mPend && !mDsDone, mErr);
      end
      checks++;
      if (link_we !== mLinkWe || link_rd !== (mLinkWe ? mLinkRd : 5'd0) || link_data !== (mLinkWe ? mLinkData : 32'd0)) begin
        failures++; $display("[TB] FAIL rnd_link cyc=%0d got=we%b/rd%0d/d%h exp=we%b/rd%0d/d%h", cyc, link_we, link_rd, link_data, mLinkWe, mLinkRd, mLinkData);
      end
      checks++;
      if (taken_cnt !== mTaken[CW-1:0] || nt_cnt !== mNt[CW-1:0]) begin
        failures++; $display("[TB] FAIL rnd_counters cyc=%0d got=t%0d/n%0d exp=t%0d/n%0d", cyc, taken_cnt, nt_cnt, mTaken, mNt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_beq_taken();
    test_bne_not_taken();
    test_jal_link();
    test_signed_regimm();
    test_ds_branch_err();
    test_flush();
    test_reset_mid();
    test_saturation();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
